coh_acc_ctrl: RTL and testbench
===============================

COH_ACC_CTRL -- requirements
Module: coh_acc_ctrl

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 10, coherent RAM address width; PHASE_W, 8, twiddle phase width.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, system clock; reset is synchronous and active-high, sampled on the rising edge of clk.
REQ-003 rst, in, 1, synchronous active-high reset.
REQ-004 start, in, 1, one-cycle pulse that begins one segment; ignored unless in IDLE.
REQ-005 abort, in, 1, stops the segment.
REQ-006 cfg_code_len, in, ADDR_W, number of correlation points per pass; 0 is treated as 1.
REQ-007 cfg_coh_number, in, 6, number of passes per segment; 0 is treated as 1.
REQ-008 cfg_freq_step, in, PHASE_W, twiddle phase increment per pass.
REQ-009 cfg_first_segment, in, 1, segment is the first (SegmentCount==0).
REQ-010 cor_in_valid, in, 1 and cor_in_ready, out, 1, correlator handshake.
REQ-011 cor_input_valid, out, 1, strobe to the summation datapath.
REQ-012 first_acc, out, 1 and first_segment, out, 1, datapath control aligned with cor_input_valid.
REQ-013 twiddle_phase, out, PHASE_W and twiddle_zero, out, 1, twiddle LUT index and zero-magnitude force.
REQ-014 ram_rd_en, out, 1 and ram_rd_addr, out, ADDR_W, coherent RAM read port.
REQ-015 ram_wr_en, out, 1 and ram_wr_addr, out, ADDR_W, coherent RAM write port; write data is the datapath output, driven outside this block.
REQ-016 busy, out, 1 and done, out, 1, status and a one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start.
- RUN->DRAIN on the last accept of a pass, or on abort.
- DRAIN lasts exactly 3 cycles, then goes to RUN (more passes remain), DONE (last pass), or IDLE (aborted).
- DONE->IDLE after 1 cycle.
REQ-018 On start, cfg_code_len, cfg_coh_number, cfg_freq_step and cfg_first_segment are latched; later changes to the cfg inputs have no effect until the next start.
REQ-019 cor_in_ready equals (state==RUN && !abort); an accept is cor_in_valid && cor_in_ready.
REQ-020 cor_input_valid equals the accept, combinationally, in the same cycle T.
REQ-021 Sample counter addr: reset to 0 at start and at each pass boundary; incremented per accept; the last accept of a pass is at addr == code_len-1.
REQ-022 ram_rd_en/ram_rd_addr are asserted at T+1 with the addr of the accept at T.
REQ-023 ram_wr_en/ram_wr_addr are asserted at T+3 with the same addr, via a 3-stage valid/addr delay line.
REQ-024 Pass counter coh_cnt:
- 0 at start; incremented on DRAIN exit to RUN.
- first_acc = (coh_cnt==0).
- first_segment = latched cfg_first_segment.
REQ-025 Phase accumulator:
- 0 at start; adds freq_step (mod 2^PHASE_W, wraps) on each pass boundary.
- twiddle_phase drives the accumulator value during RUN.
- twiddle_zero = first_acc.
REQ-026 DRAIN guarantees the final write of a pass (T+3) precedes the first read of the next pass (at least T+5), so no read-after-write hazard occurs for any code_len including 1.
REQ-027 The delay line advances every cycle regardless of state, so in-flight writes always complete, including after abort.
REQ-028 done pulses 1 cycle in DONE only; never on abort.
REQ-029 busy = (state != IDLE).
REQ-030 start while busy is ignored; abort in IDLE or DONE is ignored.
REQ-031 Simultaneous abort and last accept: abort wins; the sample is not accepted (ready low).

Reset
REQ-032 When rst is high at a clock edge, every output, counter, delay stage and the phase accumulator clear to 0, and the state goes to IDLE.
- Outputs: cor_in_ready=0, ram_rd_en=0, ram_wr_en=0, busy=0, done=0, twiddle_phase=0, first_acc=0.
REQ-033 Reset mid-operation discards in-flight writes: no ram_wr_en is issued after rst.

Verification
REQ-034 Scenario: code_len=4, coh_number=1, continuous valid.
- Accepts at T0..T0+3; reads at addr 0..3 at T0+1..T0+4; writes at T0+3..T0+6.
- first_acc=1, twiddle_zero=1; done at T0+7; busy falls at T0+8.
REQ-035 Scenario: code_len=3, coh_number=3, freq_step=0x90.
- twiddle_phase is 0x00, 0x90, 0x20 on passes 0, 1, 2; first_acc is 1, 0, 0.
- Exactly 3-cycle ready-low gap between passes.
REQ-036 Scenario: code_len=1, coh_number=2.
- Write of addr 0 at cycle W; next read of addr 0 occurs no earlier than W+2; 2 reads, 2 writes total.
REQ-037 Scenario: abort asserted on the 2nd accept cycle of code_len=8.
- That sample is not accepted; the 1 pending write completes; IDLE 3 cycles later; done never pulses.
REQ-038 Scenario: start asserted while busy, and cfg changed mid-segment.
- No effect on counts or phase; the segment completes with the latched config.
REQ-039 Scenario: rst asserted at the cycle after an accept.
- No ram_rd_en or ram_wr_en follows; all outputs read 0 the next cycle.

Source files
------------

// File: rtl/coh_acc_ctrl_if.sv
// Coherent-accumulation controller bus: correlator handshake, configuration,
// datapath strobes, coherent RAM port controls and status.
interface coh_acc_ctrl_if #(
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 8
);
  logic               start;
  logic               abort;
  logic [ADDR_W-1:0]  cfg_code_len;
  logic [5:0]         cfg_coh_number;
  logic [PHASE_W-1:0] cfg_freq_step;
  logic               cfg_first_segment;
  logic               cor_in_valid;
  logic               cor_in_ready;
  logic               cor_input_valid;
  logic               first_acc;
  logic               first_segment;
  logic [PHASE_W-1:0] twiddle_phase;
  logic               twiddle_zero;
  logic               ram_rd_en;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic               ram_wr_en;
  logic [ADDR_W-1:0]  ram_wr_addr;
  logic               busy;
  logic               done;

  // Side that issues commands and samples (e.g. sequencer / bench).
  modport master (
    output start, abort, cfg_code_len, cfg_coh_number, cfg_freq_step,
           cfg_first_segment, cor_in_valid,
    input  cor_in_ready, cor_input_valid, first_acc, first_segment,
           twiddle_phase, twiddle_zero, ram_rd_en, ram_rd_addr,
           ram_wr_en, ram_wr_addr, busy, done
  );

  // Controller side.
  modport slave (
    input  start, abort, cfg_code_len, cfg_coh_number, cfg_freq_step,
           cfg_first_segment, cor_in_valid,
    output cor_in_ready, cor_input_valid, first_acc, first_segment,
           twiddle_phase, twiddle_zero, ram_rd_en, ram_rd_addr,
           ram_wr_en, ram_wr_addr, busy, done
  );
endinterface

// File: rtl/coh_acc_ctrl.sv
// Coherent accumulation controller: sequences passes of correlator samples
// into a read-modify-write coherent RAM, with a 3-cycle drain between passes
// so the last write of a pass lands before the first read of the next one.
module coh_acc_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  coh_acc_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [ADDR_W-1:0]  r_len_last;
  logic [5:0]         r_coh_last;
  logic [PHASE_W-1:0] r_step;
  logic               r_first_seg;
  logic [ADDR_W-1:0]  r_addr;
  logic [5:0]         r_coh_cnt;
  logic [PHASE_W-1:0] r_phase;
  logic [1:0]         r_drain_cnt;
  logic               r_aborted;
  logic [2:0]         r_dv;
  logic [ADDR_W-1:0]  r_da [3];

  logic               w_start_ok;
  logic               w_ready;
  logic               w_accept;
  logic               w_last_acc;
  logic               w_drain_end;
  logic               w_stop;
  logic               w_more;
  logic               w_pass_adv;
  logic [ADDR_W-1:0]  w_len_last;
  logic [5:0]         w_coh_last;

  // A zero length or pass count behaves as one; store the "last index" form.
  assign w_len_last  = (bus.cfg_code_len == {ADDR_W{1'b0}}) ? {ADDR_W{1'b0}}
                                                            : bus.cfg_code_len - ADDR_W'(1);
  assign w_coh_last  = (bus.cfg_coh_number == 6'd0) ? 6'd0 : bus.cfg_coh_number - 6'd1;

  assign w_start_ok  = (r_state == S_IDLE) && bus.start;
  assign w_ready     = (r_state == S_RUN) && !bus.abort;
  assign w_accept    = w_ready && bus.cor_in_valid;
  assign w_last_acc  = w_accept && (r_addr == r_len_last);
  assign w_drain_end = (r_state == S_DRAIN) && (r_drain_cnt == 2'd2);
  // An abort seen during the drain still ends the segment early.
  assign w_stop      = r_aborted || bus.abort;
  assign w_more      = (r_coh_cnt != r_coh_last);
  assign w_pass_adv  = w_drain_end && !w_stop && w_more;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_RUN;
        else           w_next = S_IDLE;
      end
      S_RUN: begin
        if (bus.abort || w_last_acc) w_next = S_DRAIN;
        else                         w_next = S_RUN;
      end
      S_DRAIN: begin
        if (!w_drain_end)  w_next = S_DRAIN;
        else if (w_stop)   w_next = S_IDLE;
        else if (w_more)   w_next = S_RUN;
        else               w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Segment configuration, sample/pass counters and phase accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len_last  <= {ADDR_W{1'b0}};
      r_coh_last  <= 6'd0;
      r_step      <= {PHASE_W{1'b0}};
      r_first_seg <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_coh_cnt   <= 6'd0;
      r_phase     <= {PHASE_W{1'b0}};
      r_drain_cnt <= 2'd0;
      r_aborted   <= 1'b0;
    end else begin
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      if (w_start_ok) begin
        r_len_last  <= w_len_last;
        r_coh_last  <= w_coh_last;
        r_step      <= bus.cfg_freq_step;
        r_first_seg <= bus.cfg_first_segment;
        r_addr      <= {ADDR_W{1'b0}};
        r_coh_cnt   <= 6'd0;
        r_phase     <= {PHASE_W{1'b0}};
        r_aborted   <= 1'b0;
      end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
        if (bus.abort) begin
          r_aborted <= 1'b1;
        end else if (w_accept) begin
          r_addr <= w_last_acc ? {ADDR_W{1'b0}} : r_addr + ADDR_W'(1);
        end else begin
          r_aborted <= r_aborted;
        end
        if (w_pass_adv) begin
          r_coh_cnt <= r_coh_cnt + 6'd1;
          r_phase   <= r_phase + r_step;
          r_addr    <= {ADDR_W{1'b0}};
        end else begin
          r_coh_cnt <= r_coh_cnt;
        end
      end else begin
        r_aborted <= r_aborted;
      end
    end
  end

  // Read/write delay line; free-running so in-flight writes finish after abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv    <= 3'b000;
      r_da[0] <= {ADDR_W{1'b0}};
      r_da[1] <= {ADDR_W{1'b0}};
      r_da[2] <= {ADDR_W{1'b0}};
    end else begin
      r_dv    <= {r_dv[1:0], w_accept};
      r_da[0] <= r_addr;
      r_da[1] <= r_da[0];
      r_da[2] <= r_da[1];
    end
  end

  // Output decode from state and registered datapath control.
  always_comb begin
    bus.cor_in_ready    = w_ready;
    bus.cor_input_valid = w_accept;
    bus.first_acc       = (r_state == S_RUN) && (r_coh_cnt == 6'd0);
    bus.twiddle_zero    = (r_state == S_RUN) && (r_coh_cnt == 6'd0);
    bus.first_segment   = r_first_seg;
    if (r_state == S_RUN) bus.twiddle_phase = r_phase;
    else                  bus.twiddle_phase = {PHASE_W{1'b0}};
    bus.ram_rd_en       = r_dv[0];
    bus.ram_rd_addr     = r_da[0];
    bus.ram_wr_en       = r_dv[2];
    bus.ram_wr_addr     = r_da[2];
    bus.busy            = (r_state != S_IDLE);
    bus.done            = (r_state == S_DONE);
  end

endmodule

// File: tb/tb_coh_acc_ctrl.sv
// Self-checking bench for coh_acc_ctrl: a segment/pass-level reference model
// with scheduled RAM events, directed scenarios with literal expectations,
// then randomized traffic including aborts, restarts, cfg churn and resets.
module tb_coh_acc_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coh_acc_ctrl_if bus ();
  coh_acc_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int h_base = 1000000;

  // reference model state
  int m_st = M_IDLE, m_pass = 0, m_samp = 0, m_dcnt = 0, m_abt = 0;
  int m_len = 1, m_coh = 1, m_step = 0, m_first = 0;
  int sched_rd [int];
  int sched_wr [int];

  // per-cycle history for literal checks of directed scenarios
  logic h_acc [64], h_rd [64], h_wr [64], h_done [64], h_busy [64];
  logic h_ready [64], h_first [64], h_tz [64];
  logic [9:0] h_rda [64], h_wra [64];
  logic [7:0] h_phase [64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_on) begin
      automatic logic e_ready = (m_st == M_RUN) && !bus.abort;
      automatic logic e_acc   = e_ready && bus.cor_in_valid;
      automatic logic e_fa    = (m_st == M_RUN) && (m_pass == 0);
      automatic int   e_ph    = (m_st == M_RUN) ? ((m_pass * m_step) % 256) : 0;
      automatic int   rel     = cyc - h_base;
      chk("ready", 32'(bus.cor_in_ready), 32'(e_ready));
      chk("cor_input_valid", 32'(bus.cor_input_valid), 32'(e_acc));
      chk("first_acc", 32'(bus.first_acc), 32'(e_fa));
      chk("twiddle_zero", 32'(bus.twiddle_zero), 32'(e_fa));
      chk("twiddle_phase", 32'(bus.twiddle_phase), 32'(e_ph));
      chk("first_segment", 32'(bus.first_segment), 32'(m_first));
      chk("busy", 32'(bus.busy), 32'(m_st != M_IDLE));
      chk("done", 32'(bus.done), 32'(m_st == M_DONE));
      chk("ram_rd_en", 32'(bus.ram_rd_en), 32'(sched_rd.exists(cyc)));
      if (sched_rd.exists(cyc)) begin
        chk("ram_rd_addr", 32'(bus.ram_rd_addr), 32'(sched_rd[cyc]));
        sched_rd.delete(cyc);
      end
      chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(sched_wr.exists(cyc)));
      if (sched_wr.exists(cyc)) begin
        chk("ram_wr_addr", 32'(bus.ram_wr_addr), 32'(sched_wr[cyc]));
        sched_wr.delete(cyc);
      end
      if (rel >= 0 && rel < 64) begin
        h_acc[rel] = bus.cor_input_valid;  h_rd[rel] = bus.ram_rd_en;
        h_wr[rel] = bus.ram_wr_en;         h_done[rel] = bus.done;
        h_busy[rel] = bus.busy;            h_ready[rel] = bus.cor_in_ready;
        h_first[rel] = bus.first_acc;      h_tz[rel] = bus.twiddle_zero;
        h_rda[rel] = bus.ram_rd_addr;      h_wra[rel] = bus.ram_wr_addr;
        h_phase[rel] = bus.twiddle_phase;
      end
      if (rst) begin
        m_st = M_IDLE; m_pass = 0; m_samp = 0; m_dcnt = 0; m_abt = 0;
        m_first = 0; m_step = 0;
        sched_rd.delete(); sched_wr.delete();
      end else begin
        case (m_st)
          M_IDLE: if (bus.start) begin
            m_len   = (bus.cfg_code_len == 0) ? 1 : int'(bus.cfg_code_len);
            m_coh   = (bus.cfg_coh_number == 0) ? 1 : int'(bus.cfg_coh_number);
            m_step  = int'(bus.cfg_freq_step);
            m_first = int'(bus.cfg_first_segment);
            m_pass = 0; m_samp = 0; m_abt = 0; m_st = M_RUN;
          end
          M_RUN: begin
            if (bus.abort) begin
              m_abt = 1; m_dcnt = 0; m_st = M_DRAIN;
            end else if (e_acc) begin
              sched_rd[cyc + 1] = m_samp;
              sched_wr[cyc + 3] = m_samp;
              m_samp++;
              if (m_samp == m_len) begin
                m_samp = 0; m_dcnt = 0; m_st = M_DRAIN;
              end
            end
          end
          M_DRAIN: begin
            if (bus.abort) m_abt = 1;
            m_dcnt++;
            if (m_dcnt == 3) begin
              if (m_abt != 0)              m_st = M_IDLE;
              else if (m_pass == m_coh - 1) m_st = M_DONE;
              else begin m_pass++; m_st = M_RUN; end
            end
          end
          default: m_st = M_IDLE;
        endcase
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with a given config; history index 0 is this cycle.
  task automatic seg_start(input int len, input int coh, input int stp, input bit fs);
    tick();
    for (int i = 0; i < 64; i++) begin
      h_acc[i] = 1'b0; h_rd[i] = 1'b0; h_wr[i] = 1'b0; h_done[i] = 1'b0;
      h_busy[i] = 1'b0; h_ready[i] = 1'b0; h_first[i] = 1'b0; h_tz[i] = 1'b0;
      h_rda[i] = '0; h_wra[i] = '0; h_phase[i] = '0;
    end
    bus.cfg_code_len = 10'(len); bus.cfg_coh_number = 6'(coh);
    bus.cfg_freq_step = 8'(stp); bus.cfg_first_segment = fs;
    bus.start = 1'b1; bus.abort = 1'b0; bus.cor_in_valid = 1'b1;
    h_base = cyc;
  endtask

  task automatic idle_n(input int n);
    repeat (n) begin tick(); bus.start = 1'b0; bus.abort = 1'b0; end
  endtask

  function automatic int count_rd(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (h_rd[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_wr(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (h_wr[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (h_done[i] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.cor_in_valid = 1'b0;
    bus.cfg_code_len = '0; bus.cfg_coh_number = '0;
    bus.cfg_freq_step = '0; bus.cfg_first_segment = 1'b0;
    tick(); tick();
    chk_on = 1'b1;           // this cycle still in reset: reset state compared
    tick(); rst = 1'b0;
    idle_n(2);

    // code_len=4, one pass, continuous valid
    seg_start(4, 1, 8'h33, 1'b1);
    idle_n(14);
    for (int i = 1; i <= 4; i++) chk("s1_accept", 32'(h_acc[i]), 32'd1);
    chk("s1_no_5th_accept", 32'(h_acc[5]), 32'd0);
    chk("s1_rd_first", {h_rd[2], 21'd0, h_rda[2]}, {1'b1, 31'd0});
    chk("s1_rd_last", {h_rd[5], 21'd0, h_rda[5]}, {1'b1, 31'd3});
    chk("s1_wr_first", {h_wr[4], 21'd0, h_wra[4]}, {1'b1, 31'd0});
    chk("s1_wr_last", {h_wr[7], 21'd0, h_wra[7]}, {1'b1, 31'd3});
    chk("s1_wr_count", 32'(count_wr(0, 14)), 32'd4);
    chk("s1_first_acc", 32'({h_first[1], h_tz[1]}), 32'd3);
    chk("s1_done_pulse", 32'({h_done[7], h_done[8], h_done[9]}), 32'b010);
    chk("s1_busy_fall", 32'({h_busy[8], h_busy[9]}), 32'b10);

    // code_len=3, three passes, freq_step 0x90
    seg_start(3, 3, 8'h90, 1'b0);
    idle_n(24);
    chk("s2_phase_p0", 32'(h_phase[1]), 32'h00);
    chk("s2_phase_p1", 32'(h_phase[7]), 32'h90);
    chk("s2_phase_p2", 32'(h_phase[13]), 32'h20);
    chk("s2_first_acc", 32'({h_first[1], h_first[7], h_first[13]}), 32'b100);
    chk("s2_ready_gap", 32'({h_ready[3], h_ready[4], h_ready[5], h_ready[6], h_ready[7]}), 32'b10001);
    chk("s2_done", 32'(h_done[19]), 32'd1);

    // code_len=1, two passes: write then next read at least 2 cycles later
    seg_start(1, 2, 8'h05, 1'b0);
    idle_n(14);
    chk("s3_wr0", {h_wr[4], 21'd0, h_wra[4]}, {1'b1, 31'd0});
    chk("s3_no_early_rd", 32'({h_rd[4], h_rd[5]}), 32'b00);
    chk("s3_rd_next", {h_rd[6], 21'd0, h_rda[6]}, {1'b1, 31'd0});
    chk("s3_rd_total", 32'(count_rd(0, 14)), 32'd2);
    chk("s3_wr_total", 32'(count_wr(0, 14)), 32'd2);

    // abort on the second accept cycle of code_len=8
    seg_start(8, 1, 8'h00, 1'b0);
    tick(); bus.start = 1'b0;
    tick(); bus.abort = 1'b1;
    idle_n(12);
    chk("s4_abort_not_accepted", 32'({h_acc[1], h_acc[2]}), 32'b10);
    chk("s4_pending_wr", 32'(h_wr[4]), 32'd1);
    chk("s4_wr_total", 32'(count_wr(0, 14)), 32'd1);
    chk("s4_idle_after", 32'({h_busy[5], h_busy[6]}), 32'b10);
    chk("s4_no_done", 32'(count_done(0, 14)), 32'd0);

    // start while busy and cfg churn mid-segment
    seg_start(3, 2, 8'h10, 1'b1);
    tick(); bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.cfg_code_len = 10'd7; bus.cfg_coh_number = 6'd5;
    bus.cfg_freq_step = 8'h55; bus.cfg_first_segment = 1'b0;
    idle_n(16);
    chk("s5_phase_p1", 32'(h_phase[7]), 32'h10);
    chk("s5_done", 32'(h_done[13]), 32'd1);
    chk("s5_wr_total", 32'(count_wr(0, 18)), 32'd6);

    // reset the cycle after an accept
    seg_start(8, 1, 8'h00, 1'b0);
    tick(); bus.start = 1'b0;
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    idle_n(10);
    chk("s6_no_rd_after_rst", 32'(count_rd(3, 12)), 32'd0);
    chk("s6_no_wr_after_rst", 32'(count_wr(3, 12)), 32'd0);
    chk("s6_outputs_zero", 32'({h_busy[3], h_ready[3], h_first[3], h_done[3], h_phase[3]}), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      bus.start = ($urandom_range(0, 7) == 0);
      bus.abort = ($urandom_range(0, 79) == 0);
      bus.cor_in_valid = ($urandom_range(0, 9) < 7);
      bus.cfg_code_len = 10'($urandom_range(0, 6));
      bus.cfg_coh_number = 6'($urandom_range(0, 3));
      bus.cfg_freq_step = 8'($urandom);
      bus.cfg_first_segment = 1'($urandom);
    end
    tick(); rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    idle_n(4);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
